// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: drives EN/A/B of a 2-to-4 decoder so that the enabled
// outputs are selected one at a time. Each selection dwells for a programmable
// number of cycles. Break-before-make gap cycles hold EN low while the select
// lines change, so two decoder outputs are never active in the same cycle.
module decoder_scan_ctrl #(
    parameter int DWELL_W    = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               EN,
    output logic               A,
    output logic               B,
    output logic               busy,
    output logic               sweep_done
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [DWELL_W-1:0] DW_ZERO  = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DW_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]   GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]   GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam bit                 HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         mask_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [1:0]         idx_r;
    logic [1:0]         next_idx_r;
    logic               en_r;
    logic               busy_r;
    logic               sweep_done_r;

    logic [2:0]         above_s;
    logic               wrap_s;
    logic [1:0]         target_s;
    logic [DWELL_W-1:0] load_s;
    logic [1:0]         low_new_s;

    // Next set bit of m strictly above cur; bit 2 of the result flags a hit.
    function automatic logic [2:0] find_above(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) begin
                r = {1'b1, i[1:0]};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Lowest set bit of m (00 when m is empty; callers guard against that).
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                r = i[1:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Counter preload for a dwell value: a dwell of 0 behaves like 1.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == DW_ZERO) ? DW_ZERO : (d - DW_ONE);
    endfunction

    // Selection of the next index and its dwell preload at the end of a dwell period.
    always_comb begin
        above_s   = find_above(mask_r, idx_r);
        low_new_s = lowest_set(mask);
        wrap_s    = ~above_s[2];
        target_s  = above_s[1:0];
        load_s    = dwell_load(dwell_r);
        if (wrap_s) begin
            target_s = low_new_s;
            load_s   = dwell_load(dwell);
        end else begin
            target_s = above_s[1:0];
            load_s   = dwell_load(dwell_r);
        end
    end

    // Scan sequencer: state, latched configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mask_r       <= 4'b0000;
            dwell_r      <= DW_ZERO;
            cnt_r        <= DW_ZERO;
            gap_cnt_r    <= GAP_ZERO;
            idx_r        <= 2'b00;
            next_idx_r   <= 2'b00;
            en_r         <= 1'b0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
        end else if (stop) begin
            // Abort wins over start and over a wrap in the same cycle.
            state_r      <= ST_IDLE;
            en_r         <= 1'b0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sweep_done_r <= 1'b0;
                    en_r         <= 1'b0;
                    busy_r       <= 1'b0;
                    if (start && (mask != 4'b0000)) begin
                        mask_r  <= mask;
                        dwell_r <= dwell;
                        idx_r   <= low_new_s;
                        cnt_r   <= dwell_load(dwell);
                        en_r    <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ST_ACTIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    sweep_done_r <= 1'b0;
                    if (cnt_r != DW_ZERO) begin
                        cnt_r <= cnt_r - DW_ONE;
                    end else if (wrap_s && (mode || (mask == 4'b0000))) begin
                        // End of sweep with nothing further to scan.
                        if (!mode) begin
                            mask_r  <= mask;
                            dwell_r <= dwell;
                        end else begin
                            mask_r  <= mask_r;
                        end
                        state_r      <= ST_IDLE;
                        en_r         <= 1'b0;
                        busy_r       <= 1'b0;
                        sweep_done_r <= 1'b1;
                    end else begin
                        if (wrap_s) begin
                            mask_r       <= mask;
                            dwell_r      <= dwell;
                            sweep_done_r <= 1'b1;
                        end else begin
                            sweep_done_r <= 1'b0;
                        end
                        cnt_r <= load_s;
                        if (HAS_GAP) begin
                            next_idx_r <= target_s;
                            gap_cnt_r  <= GAP_LOAD;
                            en_r       <= 1'b0;
                            state_r    <= ST_GAP;
                        end else begin
                            idx_r   <= target_s;
                            en_r    <= 1'b1;
                            state_r <= ST_ACTIVE;
                        end
                    end
                end
                ST_GAP: begin
                    sweep_done_r <= 1'b0;
                    if (gap_cnt_r != GAP_ZERO) begin
                        gap_cnt_r <= gap_cnt_r - GAP_ONE;
                    end else begin
                        // Select and enable change together only here, after EN was low.
                        idx_r   <= next_idx_r;
                        en_r    <= 1'b1;
                        state_r <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    en_r         <= 1'b0;
                    busy_r       <= 1'b0;
                    sweep_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign EN         = en_r;
    assign A          = idx_r[1];
    assign B          = idx_r[0];
    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl. Expected output traces are built
// from the scan rules (set bits in ascending order, dwell, gap, sweep end) as
// a queue of {EN, A, B, busy, sweep_done} words.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [7:0] dwell = 8'd0;
    logic       EN, A, B, busy, sweep_done;

    int n_assert = 0;
    int n_fail = 0;
    logic [4:0] exp_q[$];

    decoder_scan_ctrl #(.DWELL_W(8), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .mask(mask), .dwell(dwell), .EN(EN), .A(A), .B(B), .busy(busy),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ent(input bit en, input int ab, input bit bz, input bit sd);
        logic [1:0] a2;
        a2 = ab[1:0];
        return {en, a2, bz, sd};
    endfunction

    task automatic check(input string tag, input logic [4:0] e);
        logic [4:0] o;
        o = {EN, A, B, busy, sweep_done};
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: EN/A/B/busy/sweep_done observed %b expected %b", tag, o, e);
        end
    endtask

    function automatic int lo_bit(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int hi_bit(input logic [3:0] m);
        for (int i = 3; i >= 0; i--) if (m[i]) return i;
        return 0;
    endfunction

    // One full sweep over mask m; ends=1 means the controller goes idle afterwards.
    task automatic add_sweep(input logic [3:0] m, input int d, input bit ends);
        int de;
        de = (d == 0) ? 1 : d;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                for (int c = 0; c < de; c++) exp_q.push_back(ent(1'b1, i, 1'b1, 1'b0));
                if (i != hi_bit(m)) exp_q.push_back(ent(1'b0, i, 1'b1, 1'b0));
                else if (ends)      exp_q.push_back(ent(1'b0, i, 1'b0, 1'b1));
                else                exp_q.push_back(ent(1'b0, i, 1'b1, 1'b1));
            end
        end
    endtask

    // Check queued cycles in order; optionally pulse start randomly while busy.
    task automatic run_q(input string tag, input bit poke);
        logic [4:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, e);
            start = (poke && e[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] m, input int d, input bit md);
        mask = m;
        dwell = d[7:0];
        mode = md;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        logic [3:0] rm;
        int rd;
        bit rmd;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("reset", ent(1'b0, 0, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", ent(1'b0, 0, 1'b0, 1'b0));

        // Test 1: continuous scan, mask 1111, dwell 2
        do_start(4'hF, 2, 1'b0);
        add_sweep(4'hF, 2, 1'b0);
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        run_q("t1_cont", 1'b0);
        do_stop();
        check("t1_stop_in_gap", ent(1'b0, 0, 1'b0, 1'b0));

        // Test 4: stop with start during second cycle at AB=01
        do_start(4'hF, 2, 1'b0);
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b0, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b1, 1, 1'b1, 1'b0));
        run_q("t4_pre", 1'b0);
        check("t4_second_active", ent(1'b1, 1, 1'b1, 1'b0));
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check("t4_stop", ent(1'b0, 1, 1'b0, 1'b0));
        tick();
        check("t4_idle_hold", ent(1'b0, 1, 1'b0, 1'b0));
        do_start(4'hF, 2, 1'b0);
        check("t4_restart", ent(1'b1, 0, 1'b1, 1'b0));
        do_stop();

        // Test 2: single sweep, mask 1010, dwell 1
        do_start(4'hA, 1, 1'b1);
        add_sweep(4'hA, 1, 1'b1);
        exp_q.push_back(ent(1'b0, 3, 1'b0, 1'b0));
        run_q("t2_single", 1'b0);

        // Test 3: dwell 0, single-bit mask, continuous
        do_start(4'h4, 0, 1'b0);
        add_sweep(4'h4, 0, 1'b0);
        add_sweep(4'h4, 0, 1'b0);
        add_sweep(4'h4, 0, 1'b0);
        exp_q.push_back(ent(1'b1, 2, 1'b1, 1'b0));
        run_q("t3_dwell0", 1'b0);
        do_stop();
        check("t3_stop", ent(1'b0, 2, 1'b0, 1'b0));

        // Test 5: start with empty mask, then start while busy
        mask = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_mask0", ent(1'b0, 2, 1'b0, 1'b0));
        tick();
        check("t5_mask0_hold", ent(1'b0, 2, 1'b0, 1'b0));
        do_start(4'h3, 3, 1'b0);
        add_sweep(4'h3, 3, 1'b0);
        add_sweep(4'h3, 3, 1'b0);
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        run_q("t5_start_busy", 1'b1);
        do_stop();
        check("t5_stop", ent(1'b0, 0, 1'b0, 1'b0));

        // Mask changes apply only at the wrap; an empty re-latched mask ends the scan
        do_start(4'hF, 1, 1'b0);
        mask = 4'h1;
        add_sweep(4'hF, 1, 1'b0);
        add_sweep(4'h1, 1, 1'b0);
        run_q("relatch", 1'b0);
        mask = 4'h0;
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b0, 0, 1'b0, 1'b1));
        exp_q.push_back(ent(1'b0, 0, 1'b0, 1'b0));
        run_q("relatch_empty", 1'b0);

        // Test 6: reset while in GAP at AB=01
        do_start(4'hF, 1, 1'b0);
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b0, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b1, 1, 1'b1, 1'b0));
        run_q("t6_pre", 1'b0);
        check("t6_in_gap", ent(1'b0, 1, 1'b1, 1'b0));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_reset_in_gap", ent(1'b0, 0, 1'b0, 1'b0));
        tick();
        do_start(4'hF, 2, 1'b0);
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b1, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b0, 0, 1'b1, 1'b0));
        exp_q.push_back(ent(1'b1, 1, 1'b1, 1'b0));
        run_q("t6_restart", 1'b0);
        do_stop();

        // Randomized sweeps against the trace model
        for (int it = 0; it < 16; it++) begin
            rm  = 4'($urandom_range(1, 15));
            rd  = $urandom_range(0, 4);
            rmd = 1'($urandom_range(0, 1));
            do_start(rm, rd, rmd);
            if (rmd) begin
                mask  = 4'($urandom_range(0, 15));
                dwell = 8'($urandom_range(0, 255));
                add_sweep(rm, rd, 1'b1);
                exp_q.push_back(ent(1'b0, hi_bit(rm), 1'b0, 1'b0));
                run_q("rand_single", 1'b1);
            end else begin
                add_sweep(rm, rd, 1'b0);
                add_sweep(rm, rd, 1'b0);
                exp_q.push_back(ent(1'b1, lo_bit(rm), 1'b1, 1'b0));
                run_q("rand_cont", 1'b1);
                do_stop();
                check("rand_stop", ent(1'b0, lo_bit(rm), 1'b0, 1'b0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
Sequencer placed directly upstream of the 2-to-4 decoder. It drives the decoder's EN, A and B inputs so the four decoder outputs are selected one at a time. Typical use is multiplexed digit or row scanning.
Each selected output dwells for a programmable number of cycles. Outputs in a skip mask are left out. When the select changes, break-before-make gap cycles hold EN low so two decoder outputs are never active in the same cycle.

Parameters:
DWELL_W, 8, width of the dwell-count input.
GAP_CYCLES, 1, number of EN-low cycles inserted between two consecutive selections (0 means no gap).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  single-cycle request to begin scanning.
stop  input  1  abort request; forces IDLE.
mode  input  1  0 = continuous scan, 1 = single sweep.
mask  input  4  enable bit per decoder output; bit i = select index i = {A,B}.
dwell  input  DWELL_W  cycles EN stays high per selection.
EN  output  1  decoder enable (registered).
A  output  1  select MSB (registered).
B  output  1  select LSB (registered).
busy  output  1  high in ACTIVE or GAP.
sweep_done  output  1  one-cycle pulse at the end of each full sweep.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, EN=0, {A,B}=00, busy=0, sweep_done=0, internal mask/dwell copies=0, counter=0. This applies at any point, including mid-scan.
- States: IDLE, ACTIVE, GAP. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - EN=0, busy=0, and {A,B} hold their last value.
  - start=1 with mask!=0: latch mask and dwell, load {A,B} = lowest set index of mask, set EN=1, busy=1, go to ACTIVE. All of this is visible the cycle after start.
  - start=1 with mask=0: ignored.
- ACTIVE:
  - EN=1 for exactly max(dwell_latched,1) cycles; dwell=0 is treated as 1.
  - On the last dwell cycle, compute next = next set bit of the latched mask strictly above the current index. If there is none, wrap to the lowest set bit; that is a wrap, i.e. end of sweep.
  - Wrap in single mode (mode=1): go to IDLE, EN=0, busy=0, sweep_done=1 for one cycle. {A,B} keep the last index.
  - Wrap in continuous mode: sweep_done=1 for one cycle (the first cycle after the last ACTIVE cycle), and re-latch mask and dwell from the inputs. If the re-latched mask=0, go to IDLE as in single mode.
  - No wrap, or wrap continuing: go to GAP if GAP_CYCLES>0, otherwise straight to ACTIVE with the new index.
  - A mask with a single set bit wraps every dwell period. The same index is reselected, with a gap if GAP_CYCLES>0.
- GAP:
  - EN=0, busy=1, and {A,B} hold the old index for GAP_CYCLES cycles.
  - Then EN=1 and {A,B}=next index, updated on the same edge, entering ACTIVE.
- mode is sampled only at the wrap decision.
- mask and dwell changes mid-sweep have no effect until the next wrap, or until a start from IDLE.
- stop=1 in any state:
  - Next cycle: IDLE, EN=0, busy=0, {A,B} hold, no sweep_done pulse.
  - stop has priority over start and over a coincident wrap.
- start while busy=1 is ignored.
- EN=1 and a change of {A,B} never occur on the same edge except on entry to ACTIVE, when EN was 0 in the preceding cycle.

Test Plan:
1. Reset, then start at edge T0, mask=1111, dwell=2, mode=0 (continuous), GAP_CYCLES=1:
   - Cycles T1–T2: EN=1, AB=00. T3: EN=0, AB=00. T4–T5: EN=1, AB=01. T6: gap. T7–T8: AB=10. T9: gap. T10–T11: AB=11.
   - T12: sweep_done=1, EN=0. T13: AB=00, EN=1.
2. mask=1010, dwell=1, mode=1 (single sweep):
   - EN=1 with AB=01 for one cycle, one gap cycle, then AB=11 for one cycle.
   - Next cycle: IDLE with busy=0, EN=0, AB=11, sweep_done=1.
3. dwell=0 and mask=0100:
   - Each ACTIVE period lasts 1 cycle at AB=10.
   - Continuous mode alternates EN 1,0 with sweep_done on every gap cycle.
4. stop asserted during the second ACTIVE cycle of test 1, together with start=1:
   - Next cycle: EN=0, busy=0, AB unchanged, no sweep_done.
   - A later start restarts at AB=00.
5. start with mask=0000: no response, busy stays 0. Also, start while busy: the sequence is unchanged.
6. rst_n=0 while in GAP: the next edge gives EN=0, AB=00, busy=0, sweep_done=0. After release, start behaves as in test 1.
